core_sequencer: RTL

Multi-cycle control FSM for the RV32I/Zicsr core. It fetches each instruction over the instruction-memory handshake and latches it into the instruction register, which feeds `CtrlUnit`. It then sequences execute, data-memory access and write-back from the decoded control flags. It owns the PC, the retired-instruction counter and the sticky halt on illegal instructions and misaligned control transfers.

---
 rtl/core_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control FSM for an RV32I/Zicsr core. Fetches each instruction
// over a request/ack handshake into the instruction register, then sequences
// decode, execute, optional data-memory access and write-back using the
// decoded flags from CtrlUnit. Owns the PC, the 64-bit retired-instruction
// counter and the sticky halt state.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata    instruction fetch handshake
//   ir                         instruction register (to CtrlUnit)
//   rd_w..is_csr, illegal      decoded control flags
//   br_taken, next_target      branch result / redirect target (valid in WB)
//   dmem_req/we/ack            data access handshake
//   rf_we, csr_en              write-back strobes (single-cycle, WB only)
//   pc, state, halted, instret architectural/status outputs
module core_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    input  logic            rd_w,
    input  logic            is_branch,
    input  logic            is_jmp,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_fence,
    input  logic            is_fencei,
    input  logic            is_csr,
    input  logic            illegal,
    input  logic            br_taken,
    input  logic [XLEN-1:0] next_target,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            rf_we,
    output logic            csr_en,
    output logic [XLEN-1:0] pc,
    output logic [2:0]      state,
    output logic            halted,
    output logic [63:0]     instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [63:0]     instret_q, instret_d;

    logic redirect;
    logic misalign;
    logic commit;

    // A taken control transfer to a non-word-aligned target aborts the
    // instruction in WB instead of committing it.
    assign redirect = is_jmp | (is_branch & br_taken);
    assign misalign = redirect & (next_target[1:0] != 2'b00);
    assign commit   = (state_q == S_WB) & ~misalign;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = illegal ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (is_load | is_store) ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack) state_d = S_WB;
            S_WB:     state_d = misalign ? S_HALT : S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Architectural state next values: IR loads on fetch ack, PC and
    // instret advance together only on a committing WB.
    always_comb begin
        ir_d      = ir_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        if (state_q == S_FETCH && imem_ack) begin
            ir_d = imem_rdata;
        end
        if (commit) begin
            pc_d      = redirect ? next_target : pc_q + XLEN'(4);
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir_q      <= NOP;
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end

    // Output logic. The fetch request is also qualified by rst_n so it is
    // low while reset is held and drops the instant reset asserts.
    always_comb begin
        imem_req = (state_q == S_FETCH) & rst_n;
        dmem_req = (state_q == S_MEM);
        dmem_we  = (state_q == S_MEM) & is_store;
        rf_we    = commit & rd_w & ~is_fence & ~is_fencei;
        csr_en   = commit & is_csr;
        halted   = (state_q == S_HALT);
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign instret   = instret_q;
    assign state     = state_q;

endmodule
